// File: rtl/ram_io_responder.sv
// RAM plus memory-mapped I/O responder: byte RAM, UART tx/rx FIFOs,
// a halt flag and a sticky overflow flag behind two I/O ports.
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FIFO_LOG   = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rw_select,
  input  logic [31:0] addr_in,
  input  logic [7:0]  ram_store_data,
  output logic [7:0]  ram_load_data,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        halt_out,
  output logic        io_overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] FULL_CNT = (FIFO_LOG + 1)'(DEPTH);
  localparam logic [FIFO_LOG:0] NEAR_CNT = (FIFO_LOG + 1)'(DEPTH - 2);

  typedef enum logic {
    PORT_DATA = 1'b0,
    PORT_CTRL = 1'b1
  } io_port_e;

  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] tx_buf [DEPTH];
  logic [7:0] rx_buf [DEPTH];

  logic [FIFO_LOG-1:0] tx_rptr, tx_wptr, rx_rptr, rx_wptr;
  logic [FIFO_LOG:0]   tx_count, rx_count;

  logic     edge_vld;
  logic     edge_rw;
  io_port_e edge_port;

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic     io_region, port_hit, first_access;
  io_port_e port_sel;
  logic     tx_push_req, tx_push, tx_pop;
  logic     rx_pop, rx_push;
  logic     overflow_set, halt_set;
  logic [7:0] io_rdata;

  assign ram_idx        = addr_in[ADDR_WIDTH-1:0];
  assign tx_valid       = (tx_count != '0);
  assign tx_data        = tx_buf[tx_rptr];
  assign io_buffer_full = (tx_count >= NEAR_CNT);

  // Address decode, access-edge detection and FIFO handshake qualification.
  always_comb begin
    io_region    = (addr_in[17:16] == 2'b11);
    port_hit     = io_region && ((addr_in == 32'h0003_0000) || (addr_in == 32'h0003_0004));
    port_sel     = addr_in[2] ? PORT_CTRL : PORT_DATA;
    // A held port access only acts once: compare against last enabled cycle.
    first_access = port_hit && !(edge_vld && (edge_rw == rw_select) && (edge_port == port_sel));

    tx_pop       = rdy_in && tx_valid && tx_ready;
    tx_push_req  = rdy_in && first_access && rw_select && (port_sel == PORT_DATA);
    tx_push      = tx_push_req && ((tx_count != FULL_CNT) || tx_pop);

    rx_pop       = rdy_in && first_access && !rw_select && (port_sel == PORT_DATA) && (rx_count != '0);
    rx_push      = rdy_in && rx_valid && ((rx_count != FULL_CNT) || rx_pop);

    overflow_set = (tx_push_req && !tx_push) || (rdy_in && rx_valid && !rx_push);
    halt_set     = rdy_in && first_access && rw_select && (port_sel == PORT_CTRL);
  end

  // Read data for the I/O region; a repeated data-port read keeps the old byte.
  always_comb begin
    io_rdata = ram_load_data;
    if (!port_hit) begin
      io_rdata = '0;
    end else if (port_sel == PORT_CTRL) begin
      io_rdata = 8'(rx_count);
    end else if (first_access) begin
      io_rdata = (rx_count != '0) ? rx_buf[rx_rptr] : '0;
    end
  end

  // RAM byte write; contents are never touched by reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && rw_select && !io_region) begin
      mem[ram_idx] <= ram_store_data;
    end
  end

  // FIFO storage writes, unreset since only occupied slots are ever observed.
  always_ff @(posedge clk_in) begin
    if (!rst_in && tx_push) begin
      tx_buf[tx_wptr] <= ram_store_data;
    end
    if (!rst_in && rx_push) begin
      rx_buf[rx_wptr] <= rx_data;
    end
  end

  // Pointers, counts, edge register, load register and status flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_rptr       <= '0;
      tx_wptr       <= '0;
      rx_rptr       <= '0;
      rx_wptr       <= '0;
      tx_count      <= '0;
      rx_count      <= '0;
      edge_vld      <= 1'b0;
      edge_rw       <= 1'b0;
      edge_port     <= PORT_DATA;
      ram_load_data <= '0;
      halt_out      <= 1'b0;
      io_overflow   <= 1'b0;
    end else if (rdy_in) begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      edge_vld  <= port_hit;
      edge_rw   <= rw_select;
      edge_port <= port_sel;
      if (!rw_select) begin
        ram_load_data <= io_region ? io_rdata : mem[ram_idx];
      end
      if (halt_set)     halt_out    <= 1'b1;
      if (overflow_set) io_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Randomized scoreboard bench for ram_io_responder with a queue-based model.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        rw_select = 1'b0;
  logic [31:0] addr_in = '0;
  logic [7:0]  ram_store_data = '0;
  logic [7:0]  ram_load_data;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        halt_out;
  logic        io_overflow;

  ram_io_responder #(.ADDR_WIDTH(17), .FIFO_LOG(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rw_select(rw_select),
    .addr_in(addr_in), .ram_store_data(ram_store_data), .ram_load_data(ram_load_data),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .halt_out(halt_out), .io_overflow(io_overflow)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] load;
    logic       txv;
    logic [7:0] txd;
    logic       full;
    logic       halt;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] m_load = '0;
  logic       m_halt = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_last = -1;
  logic [31:0] prev_addr = '0;
  bit          prev_rw = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus; model the effect of the coming edge and queue it.
  task automatic do_cycle(input bit rst, input bit rdy, input bit rw, input logic [31:0] addr,
                          input logic [7:0] wd, input bit txr, input bit rxv, input logic [7:0] rxd);
    exp_t e;
    bit io, fresh, txpop;
    int key, tx_n, rx_n;
    @(negedge clk_in);
    rst_in = rst; rdy_in = rdy; rw_select = rw; addr_in = addr;
    ram_store_data = wd; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    prev_addr = addr; prev_rw = rw;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_load = '0; m_halt = 1'b0; m_ovf = 1'b0; m_last = -1;
    end else if (rdy) begin
      io = (addr[17:16] == 2'b11);
      key = -1;
      if (addr == 32'h30000) key = rw ? 2 : 0;
      if (addr == 32'h30004) key = rw ? 3 : 1;
      fresh = (key >= 0) && (key != m_last);
      tx_n = txq.size();
      rx_n = rxq.size();
      txpop = (tx_n > 0) && txr;
      if (!rw) begin
        if (!io) m_load = ram_m[int'(addr[16:0])];
        else if (addr == 32'h30000) begin
          if (fresh) m_load = (rx_n > 0) ? rxq.pop_front() : 8'h00;
        end
        else if (addr == 32'h30004) m_load = 8'(rx_n);
        else m_load = 8'h00;
      end else begin
        if (!io) ram_m[int'(addr[16:0])] = wd;
        else if (addr == 32'h30000 && fresh) begin
          if (tx_n < 8 || txpop) txq.push_back(wd);
          else m_ovf = 1'b1;
        end
        else if (addr == 32'h30004 && fresh) m_halt = 1'b1;
      end
      if (txpop) void'(txq.pop_front());
      if (rxv) begin
        if (rx_n < 8 || rxq.size() < rx_n) rxq.push_back(rxd);
        else m_ovf = 1'b1;
      end
      m_last = key;
    end
    e.load = m_load;
    e.txv  = (txq.size() > 0);
    e.txd  = (txq.size() > 0) ? txq[0] : 8'h00;
    e.full = (txq.size() >= 6);
    e.halt = m_halt;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit txr, input bit rxv, input logic [7:0] rxd);
    do_cycle(1'b0, 1'b1, 1'b1, 32'h30008, 8'h00, txr, rxv, rxd);
  endtask

  // Monitor: compare DUT outputs shortly after each edge against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ram_load_data", ram_load_data, e.load);
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, e.txv});
        if (e.txv) chk("tx_data", tx_data, e.txd);
        chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, e.full});
        chk("halt_out", {7'b0, halt_out}, {7'b0, e.halt});
        chk("io_overflow", {7'b0, io_overflow}, {7'b0, e.ovf});
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] a;
    bit rw;
    int r;
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 8'h55);
    for (int unsigned i = 0; i < 16; i++)
      do_cycle(1'b0, 1'b1, 1'b1, i, 8'($urandom), 1'b0, 1'b0, 8'h00);

    // RAM write then read-back
    do_cycle(1'b0, 1'b1, 1'b1, 32'h10, 8'hA5, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h10, 8'h00, 1'b0, 1'b0, 8'h00);

    // Held tx write pushes once, then drain
    repeat (3) do_cycle(1'b0, 1'b1, 1'b1, 32'h30000, 8'h41, 1'b0, 1'b0, 8'h00);
    idle(1'b1, 1'b0, 8'h00);

    // Fill tx past capacity
    for (int unsigned i = 0; i < 9; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1, 32'h30000, 8'(8'h60 + i), 1'b0, 1'b0, 8'h00);
      idle(1'b0, 1'b0, 8'h00);
    end

    // Push+pop at full, then rdy_in low
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int unsigned i = 0; i < 8; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1, 32'h30000, 8'(8'h80 + i), 1'b0, 1'b0, 8'h00);
      idle(1'b0, 1'b0, 8'h00);
    end
    do_cycle(1'b0, 1'b1, 1'b1, 32'h30000, 8'h99, 1'b1, 1'b0, 8'h00);
    repeat (2) do_cycle(1'b0, 1'b0, 1'b1, 32'h30000, 8'h77, 1'b1, 1'b1, 8'h33);
    repeat (9) idle(1'b1, 1'b0, 8'h00);

    // rx path: two bytes, status read, pops and pop on empty
    idle(1'b0, 1'b1, 8'h11);
    idle(1'b0, 1'b1, 8'h22);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);

    // Halt, reset, RAM survives
    do_cycle(1'b0, 1'b1, 1'b1, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1'b0, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b1, 1'b1, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h10, 8'h00, 1'b0, 1'b0, 8'h00);

    // Randomized traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      rw = 1'($urandom);
      case (r)
        0, 1, 2, 3: a = 32'($urandom_range(0, 15));
        4, 5:       a = 32'h30000;
        6:          a = 32'h30004;
        7:          a = ($urandom_range(0, 1) == 0) ? 32'h30008 : 32'h3FFFC;
        default:    begin a = prev_addr; if ($urandom_range(0, 1) == 0) rw = prev_rw; end
      endcase
      do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 85, rw, a, 8'($urandom),
               $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, 8'($urandom));
    end
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1'b0, 1'b0, 8'h00);
    stim_done = 1'b1;
  end

  // End of run: bounded drain of the scoreboard, then summary.
  initial begin
    wait (stim_done);
    for (int unsigned k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_in);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
